// File: rtl/bldc_commutation_ctrl.sv
// Six-step trapezoidal commutation sequencer for the BLDC power stage.
// It applies high-side PWM, inserts break-before-make dead time, and latches a fault when the sector stays invalid.
module bldc_commutation_ctrl #(
  parameter int pwm_clk_freq_hz = 100_286_000,
  parameter int pwm_freq_hz     = 100_000,
  parameter int duty_width      = $clog2(pwm_clk_freq_hz / pwm_freq_hz) + 1,
  parameter int dead_cycles     = 10,
  parameter int fault_cycles    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            sector,
  input  logic                  run,
  input  logic                  dir,
  input  logic [duty_width-1:0] duty,
  input  logic                  fault_clear,
  output logic [5:0]            phase_enable,
  output logic [1:0]            state,
  output logic                  fault,
  output logic                  pwm_sync
);

  localparam int PERIOD = pwm_clk_freq_hz / pwm_freq_hz;
  localparam logic [duty_width-1:0] PERIOD_W = duty_width'(PERIOD);
  localparam logic [duty_width-1:0] LAST_CNT = duty_width'(PERIOD - 1);
  localparam int DEAD_W = $clog2(dead_cycles + 1);
  localparam int INV_W  = $clog2(fault_cycles + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(dead_cycles);
  localparam logic [INV_W-1:0]  INV_LIMIT = INV_W'(fault_cycles);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [duty_width-1:0] pwm_cnt;
  logic [duty_width-1:0] duty_eff;
  logic                  pwm_on;
  logic                  sector_valid;
  logic [2:0]            idx;
  logic [2:0]            key_q;
  logic                  key_change;
  logic [INV_W-1:0]      inv_cnt;
  logic [INV_W-1:0]      inv_next;
  logic                  fault_hit;
  logic [DEAD_W-1:0]     dead_cnt;
  logic [DEAD_W-1:0]     dead_next;
  logic [1:0]            state_next;
  logic [5:0]            drive_pattern;

  // The PWM carrier runs in every state, so duty and sync timing do not depend on the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt  <= '0;
      pwm_sync <= 1'b0;
    end else if (pwm_cnt == LAST_CNT) begin
      pwm_cnt  <= '0;
      pwm_sync <= 1'b1;
    end else begin
      pwm_cnt  <= pwm_cnt + duty_width'(1);
      pwm_sync <= 1'b0;
    end
  end

  assign duty_eff     = (duty >= PERIOD_W) ? PERIOD_W : duty;
  assign pwm_on       = (pwm_cnt < duty_eff);
  assign sector_valid = (sector < 3'd6);

  // For CCW, the table index is shifted half a turn (+3 mod 6).
  always_comb begin
    idx = sector;
    if (dir) begin
      idx = (sector >= 3'd3) ? (sector - 3'd3) : (sector + 3'd3);
    end
  end

  assign key_change = sector_valid && (idx != key_q);

  always_comb begin
    inv_next = '0;
    if (!sector_valid) begin
      inv_next = (inv_cnt >= INV_LIMIT) ? INV_LIMIT : (inv_cnt + INV_W'(1));
    end
  end

  assign fault_hit = (inv_next >= INV_LIMIT);

  // A fault trip takes priority over every other event. An invalid sector holds the dead counter.
  always_comb begin
    state_next = state;
    dead_next  = dead_cnt;
    case (state)
      ST_IDLE: begin
        if (fault_hit) begin
          state_next = ST_FAULT;
        end else if (run && sector_valid) begin
          state_next = ST_DEAD;
          dead_next  = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (fault_hit) begin
          state_next = ST_FAULT;
        end else if (!run) begin
          state_next = ST_IDLE;
        end else if (key_change) begin
          dead_next = DEAD_LOAD;
        end else if (sector_valid) begin
          if (dead_cnt <= DEAD_W'(1)) begin
            state_next = ST_DRIVE;
          end else begin
            dead_next = dead_cnt - DEAD_W'(1);
          end
        end
      end
      ST_DRIVE: begin
        if (fault_hit) begin
          state_next = ST_FAULT;
        end else if (!run) begin
          state_next = ST_IDLE;
        end else if (!sector_valid || key_change) begin
          state_next = ST_DEAD;
          dead_next  = DEAD_LOAD;
        end
      end
      ST_FAULT: begin
        if (fault_clear && !run) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit order is {AH,BH,CH,AL,BL,CL}. Only the high side is chopped by the PWM.
  always_comb begin
    drive_pattern = '0;
    case (idx)
      3'd0:    drive_pattern = {pwm_on, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      3'd1:    drive_pattern = {pwm_on, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      3'd2:    drive_pattern = {1'b0, pwm_on, 1'b0, 1'b0, 1'b0, 1'b1};
      3'd3:    drive_pattern = {1'b0, pwm_on, 1'b0, 1'b1, 1'b0, 1'b0};
      3'd4:    drive_pattern = {1'b0, 1'b0, pwm_on, 1'b1, 1'b0, 1'b0};
      3'd5:    drive_pattern = {1'b0, 1'b0, pwm_on, 1'b0, 1'b1, 1'b0};
      default: drive_pattern = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      dead_cnt     <= '0;
      inv_cnt      <= '0;
      key_q        <= '0;
      phase_enable <= '0;
    end else begin
      state    <= state_next;
      dead_cnt <= dead_next;
      inv_cnt  <= inv_next;
      if (sector_valid) begin
        key_q <= idx;
      end
      phase_enable <= (state_next == ST_DRIVE) ? drive_pattern : 6'b000000;
    end
  end

  assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Testbench for bldc_commutation_ctrl.
// Table vectors pass through an expectation queue; hand-written sequences cover PWM duty, sync spacing, fault handling and async reset.
module tb_bldc_commutation_ctrl;

  localparam int DW = 11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic          clk;
  logic          reset;
  logic [2:0]    sector;
  logic          run;
  logic          dir;
  logic [DW-1:0] duty;
  logic          fault_clear;
  logic [5:0]    phase_enable;
  logic [1:0]    state;
  logic          fault;
  logic          pwm_sync;

  typedef struct {
    string         name;
    logic [2:0]    sector;
    logic          run;
    logic          dir;
    logic [DW-1:0] duty;
    logic          fault_clear;
    logic [5:0]    exp_phase;
    logic [1:0]    exp_state;
    logic          exp_fault;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] phase;
    logic [1:0] st;
    logic       flt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  bldc_commutation_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sector       (sector),
    .run          (run),
    .dir          (dir),
    .duty         (duty),
    .fault_clear  (fault_clear),
    .phase_enable (phase_enable),
    .state        (state),
    .fault        (fault),
    .pwm_sync     (pwm_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVecs(input int n, input string name, input logic [2:0] sec, input logic r,
                         input logic d, input logic [DW-1:0] dty, input logic fc,
                         input logic [5:0] ph, input logic [1:0] st, input logic flt);
    vec_t v;
    v.name = name; v.sector = sec; v.run = r; v.dir = d; v.duty = dty; v.fault_clear = fc;
    v.exp_phase = ph; v.exp_state = st; v.exp_fault = flt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic driveInputs(input logic [2:0] sec, input logic r, input logic d,
                             input logic [DW-1:0] dty, input logic fc);
    sector = sec; run = r; dir = d; duty = dty; fault_clear = fc;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveInputs(v.sector, v.run, v.dir, v.duty, v.fault_clear);
    e.name = v.name; e.phase = v.exp_phase; e.st = v.exp_state; e.flt = v.exp_fault;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    n_compared++;
    if (sb.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb.pop_front();
      if (phase_enable !== e.phase || state !== e.st || fault !== e.flt) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got phase=%b state=%0d fault=%b, required phase=%b state=%0d fault=%b",
                 e.name, phase_enable, state, fault, e.phase, e.st, e.flt);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic waitState(input logic [1:0] target, input int max_cycles, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (state == target) begin
        found = 1'b1;
        break;
      end
    end
    n_compared++;
    if (!found) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got state=%0d after %0d cycles, required state=%0d", name, state, max_cycles, target);
    end
  endtask

  task automatic stepVec(input logic [2:0] sec, input logic r, input logic fc, input string name,
                         input logic [5:0] ph, input logic [1:0] st, input logic flt);
    vec_t v;
    v.name = name; v.sector = sec; v.run = r; v.dir = 1'b0; v.duty = 11'd2000; v.fault_clear = fc;
    v.exp_phase = ph; v.exp_state = st; v.exp_fault = flt;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int ah_count;
    int low_bad;
    int gap;
    int ah_seen;
    bit got_sync;

    reset = 1'b1;
    driveInputs(3'd0, 1'b0, 1'b0, '0, 1'b0);

    addVecs(2,  "idle",         3'd0, 1'b0, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_IDLE,  1'b0);
    addVecs(10, "start_dead",   3'd0, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(3,  "drive_s0",     3'd0, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b100010, ST_DRIVE, 1'b0);
    addVecs(10, "key_dead",     3'd1, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(3,  "drive_s1",     3'd1, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b100001, ST_DRIVE, 1'b0);
    addVecs(10, "dir_dead",     3'd0, 1'b1, 1'b1, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(3,  "drive_ccw",    3'd0, 1'b1, 1'b1, 11'd2000, 1'b0, 6'b010100, ST_DRIVE, 1'b0);
    addVecs(2,  "coast",        3'd0, 1'b0, 1'b1, 11'd2000, 1'b0, 6'b000000, ST_IDLE,  1'b0);
    addVecs(10, "dead_duty0",   3'd0, 1'b1, 1'b1, 11'd0,    1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(3,  "drive_duty0",  3'd0, 1'b1, 1'b1, 11'd0,    1'b0, 6'b000100, ST_DRIVE, 1'b0);
    addVecs(1,  "coast2",       3'd0, 1'b0, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_IDLE,  1'b0);
    addVecs(5,  "reload_pre",   3'd0, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(10, "reload_dead",  3'd1, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(1,  "reload_drive", 3'd1, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b100001, ST_DRIVE, 1'b0);
    addVecs(1,  "coast3",       3'd1, 1'b0, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_IDLE,  1'b0);
    addVecs(3,  "abort_dead",   3'd2, 1'b1, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_DEAD,  1'b0);
    addVecs(1,  "abort_idle",   3'd2, 1'b0, 1'b0, 11'd2000, 1'b0, 6'b000000, ST_IDLE,  1'b0);

    #1;
    checkValue("reset_phase", 32'(phase_enable), 32'd0);
    checkValue("reset_state", 32'(state), 32'(ST_IDLE));
    checkValue("reset_fault", 32'(fault), 32'd0);
    checkValue("reset_sync",  32'(pwm_sync), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] table vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end

    // Half duty on A+B-: AH on for half the carrier period, BL held on, nothing else set.
    driveInputs(3'd0, 1'b1, 1'b0, 11'd501, 1'b0);
    waitState(ST_DRIVE, 30, "pwm_drive_entry");
    ah_count = 0;
    low_bad  = 0;
    for (int i = 0; i < 1002; i++) begin
      @(negedge clk);
      if (phase_enable[5]) ah_count++;
      if (phase_enable[4:0] !== 5'b00010) low_bad++;
    end
    checkValue("pwm_ah_on_cycles", 32'(ah_count), 32'd501);
    checkValue("pwm_low_side_bad", 32'(low_bad), 32'd0);

    // Zero duty keeps AH off; sync pulses must be one carrier period apart.
    duty = 11'd0;
    got_sync = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (pwm_sync) begin
        got_sync = 1'b1;
        break;
      end
    end
    checkValue("sync_first_seen", 32'(got_sync), 32'd1);
    gap = 0;
    ah_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      gap++;
      if (phase_enable[5]) ah_seen++;
      if (pwm_sync) break;
    end
    checkValue("sync_period", 32'(gap), 32'd1002);
    checkValue("duty0_ah_cycles", 32'(ah_seen), 32'd0);
    checkValue("duty0_state", 32'(state), 32'(ST_DRIVE));

    // Short invalid burst: fall back to dead time and recover without faulting.
    driveInputs(3'd0, 1'b1, 1'b0, 11'd2000, 1'b0);
    waitState(ST_DRIVE, 30, "fault_pre_drive");
    stepVec(3'd7, 1'b1, 1'b0, "inv3_c1", 6'b000000, ST_DEAD, 1'b0);
    stepVec(3'd7, 1'b1, 1'b0, "inv3_c2", 6'b000000, ST_DEAD, 1'b0);
    stepVec(3'd7, 1'b1, 1'b0, "inv3_c3", 6'b000000, ST_DEAD, 1'b0);
    driveInputs(3'd0, 1'b1, 1'b0, 11'd2000, 1'b0);
    waitState(ST_DRIVE, 25, "inv3_recover");
    checkValue("inv3_no_fault", 32'(fault), 32'd0);
    checkValue("inv3_phase", 32'(phase_enable), 32'(6'b100010));

    // A persistent invalid sector trips a sticky fault; clearing it requires run low.
    stepVec(3'd7, 1'b1, 1'b0, "inv4_c1", 6'b000000, ST_DEAD,  1'b0);
    stepVec(3'd7, 1'b1, 1'b0, "inv4_c2", 6'b000000, ST_DEAD,  1'b0);
    stepVec(3'd7, 1'b1, 1'b0, "inv4_c3", 6'b000000, ST_DEAD,  1'b0);
    stepVec(3'd7, 1'b1, 1'b0, "inv4_trip", 6'b000000, ST_FAULT, 1'b1);
    stepVec(3'd0, 1'b1, 1'b1, "clear_run1", 6'b000000, ST_FAULT, 1'b1);
    stepVec(3'd0, 1'b1, 1'b0, "fault_hold", 6'b000000, ST_FAULT, 1'b1);
    stepVec(3'd0, 1'b0, 1'b0, "run0_no_clear", 6'b000000, ST_FAULT, 1'b1);
    stepVec(3'd0, 1'b0, 1'b1, "clear_run0", 6'b000000, ST_IDLE, 1'b0);
    stepVec(3'd0, 1'b0, 1'b0, "idle_after_clear", 6'b000000, ST_IDLE, 1'b0);

    // Async reset in the middle of DRIVE.
    driveInputs(3'd2, 1'b1, 1'b0, 11'd2000, 1'b0);
    waitState(ST_DRIVE, 30, "reset_pre_drive");
    checkValue("pre_reset_phase", 32'(phase_enable), 32'(6'b010001));
    #2;
    reset = 1'b1;
    #1;
    checkValue("async_reset_phase", 32'(phase_enable), 32'd0);
    checkValue("async_reset_state", 32'(state), 32'(ST_IDLE));
    checkValue("async_reset_fault", 32'(fault), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    driveInputs(3'd0, 1'b0, 1'b0, 11'd0, 1'b0);
    @(negedge clk);
    checkValue("post_reset_state", 32'(state), 32'(ST_IDLE));
    checkValue("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
